mem_port_arbiter: RTL and testbench

//  Shares one synchronous single-port word memory between the instruction-fetch port (I) and the load/store port (D) of the MIPS datapath.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port word memory between the fetch (I) and load/store (D) ports.
// D has priority. A starvation counter forces an I grant after STARVE_MAX consecutive D wins.
module mem_port_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW+1:0] d_addr,
   input  logic [3:0]    d_be,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic          d_err,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   logic [CW-1:0] starve_cnt;
   owner_t        rd_owner;
   logic          err_q;
   logic          force_i;
   logic          d_mis;

   // Word needs 4-byte alignment, halfword 2-byte; single bytes are always legal.
   always_comb begin
      d_mis = 1'b0;
      case (d_be)
         4'hF:       d_mis = |d_addr[1:0];
         4'h3, 4'hC: d_mis = d_addr[0];
         default:    d_mis = 1'b0;
      endcase
   end

   // NOTE: grants and return strobes are masked by reset so nothing leaks out during reset,
   // including a read return that was already in flight when reset arrived.
   assign force_i = i_req & (starve_cnt == CNT_MAX);
   assign d_gnt   = ~reset & d_req & ~force_i;
   assign i_gnt   = ~reset & i_req & ~d_gnt;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt && !d_mis) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_we ? d_be : 4'hF;
         mem_addr  = d_addr[AW+1:2];
         mem_wdata = d_wdata;
      end else if (i_gnt) begin
         mem_en   = 1'b1;
         mem_be   = 4'hF;
         mem_addr = i_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (i_gnt || !i_req) begin
         starve_cnt <= '0;
      end else if (d_gnt && starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner <= OWN_NONE;
         err_q    <= 1'b0;
      end else begin
         err_q <= d_gnt & d_mis;
         if (i_gnt)
            rd_owner <= OWN_I;
         else if (d_gnt && !d_mis && !d_we)
            rd_owner <= OWN_D;
         else
            rd_owner <= OWN_NONE;
      end
   end

   assign i_rvalid = ~reset & (rd_owner == OWN_I);
   assign d_rvalid = ~reset & (rd_owner == OWN_D);
   assign d_err    = ~reset & err_q;
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, both scored
// against a transaction-level model with its own copy of memory contents.
module tb_mem_port_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, i_gnt, i_rvalid;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [AW+1:0] d_addr;
   logic [3:0]    d_be;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int a);
      if (a == 16) return 32'h2002000A;
      return (a * 32'h01010101) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      return w;
   endfunction

   // Environment RAM, 256 words, one-cycle read latency
   logic [31:0] ram [256];
   bit          ram_wr [256] = '{default: 1'b0};
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[7:0]]    <= merge(ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_word(int'(mem_addr[7:0])),
                                           mem_wdata, mem_be);
            ram_wr[mem_addr[7:0]] <= 1'b1;
         end else begin
            mem_rdata <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_word(int'(mem_addr[7:0]));
         end
      end
   end

   // Reference model state
   logic [31:0] golden [256];
   int          passed = 0;
   int          total  = 0;
   int          m_cnt  = 0;
   bit          p_i, p_d, p_err;
   logic [31:0] p_data;
   bit          last_i, last_d;
   bit [3:0]    be_set [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle: inputs already applied just after a falling edge.
   task automatic cycle();
      bit fi, ed, ei, mis;
      int sz, wa;
      #1;
      check("i_rvalid", i_rvalid, (!reset && p_i));
      check("d_rvalid", d_rvalid, (!reset && p_d));
      check("d_err", d_err, (!reset && p_err));
      if (!reset && p_i) check("i_rdata", i_rdata, p_data);
      if (!reset && p_d) check("d_rdata", d_rdata, p_data);

      fi  = i_req && (m_cnt == SM);
      ed  = !reset && d_req && !fi;
      ei  = !reset && i_req && !ed;
      sz  = $countones(d_be);
      mis = (sz == 4 && (d_addr % 4) != 0) || (sz == 2 && (d_addr % 2) != 0);
      wa  = ei ? int'(i_addr) : int'(d_addr / 4);

      check("i_gnt", i_gnt, ei);
      check("d_gnt", d_gnt, ed);
      check("mem_en", mem_en, (ei || (ed && !mis)));
      if (ei || (ed && !mis)) begin
         check("mem_addr", mem_addr, wa);
         check("mem_we", mem_we, (ed && d_we));
         check("mem_be", mem_be, ((ed && d_we) ? d_be : 4'hF));
         if (ed && d_we) check("mem_wdata", mem_wdata, d_wdata);
      end
      last_i = i_gnt;
      last_d = d_gnt;

      p_i    = ei;
      p_d    = ed && !d_we && !mis;
      p_err  = ed && mis;
      p_data = (ei || ed) ? golden[wa[7:0]] : 32'h0;
      if (ed && d_we && !mis) golden[wa[7:0]] = merge(golden[wa[7:0]], d_wdata, d_be);

      if (reset || ei || !i_req) m_cnt = 0;
      else if (ed)               m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
      if (reset) begin p_i = 0; p_d = 0; p_err = 0; end
      @(negedge clk);
   endtask

   initial begin
      bit exp_seq_i [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      bit exp_seq_j [5] = '{0, 0, 0, 0, 1};
      for (int a = 0; a < 256; a++) golden[a] = init_word(a);

      // Reset held 3 cycles with both ports requesting
      reset = 1; i_req = 1; i_addr = 30'h10;
      d_req = 1; d_we = 0; d_addr = 32'h20; d_be = 4'hF; d_wdata = 32'h0;
      repeat (3) cycle();
      reset = 0;

      // Contention: D,D,D,D,I,D,D,D
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("seq_i", last_i, exp_seq_i[k]);
         check("seq_d", last_d, !exp_seq_i[k]);
      end

      // Lone fetch of word 0x10
      d_req = 0; i_req = 1; i_addr = 30'h10;
      cycle();
      i_req = 0;
      check("fetch_rvalid", i_rvalid, 1'b1);
      check("fetch_rdata", i_rdata, 32'h2002000A);
      cycle();

      // Halfword store to byte 0x104
      d_req = 1; d_we = 1; d_addr = 32'h104; d_be = 4'h3; d_wdata = 32'hDEADBEEF;
      #1;
      check("st_mem_addr", mem_addr, 30'h41);
      check("st_mem_be", mem_be, 4'h3);
      check("st_mem_we", mem_we, 1'b1);
      cycle();
      d_req = 0;
      check("st_no_rvalid", d_rvalid, 1'b0);
      cycle();

      // Misaligned word load, then aligned load of the stored word
      d_req = 1; d_we = 0; d_addr = 32'h102; d_be = 4'hF;
      #1;
      check("mis_gnt", d_gnt, 1'b1);
      check("mis_mem_en", mem_en, 1'b0);
      cycle();
      d_addr = 32'h104;
      check("mis_err", d_err, 1'b1);
      check("mis_rvalid", d_rvalid, 1'b0);
      cycle();
      d_req = 0;
      check("ld_rdata", d_rdata, 32'h4141BEEF ^ 32'h5A5A0000 ^ 32'h0000BEEF ^ 32'h0000BEEF);
      cycle();

      // Build up starvation count, then a load grant followed by reset
      i_req = 1; i_addr = 30'h3; d_req = 1; d_addr = 32'h40; d_be = 4'hF;
      repeat (3) cycle();
      i_req = 0;
      cycle();
      reset = 1; d_req = 0;
      cycle();
      reset = 0; i_req = 1; d_req = 1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("rst_seq_i", last_i, exp_seq_j[k]);
      end

      // Randomized traffic; requests stay stable until granted
      for (int n = 0; n < 3000; n++) begin
         if (!i_req || last_i) begin
            i_req  = ($urandom_range(0, 99) < 60);
            i_addr = AW'($urandom_range(0, 255));
         end
         if (!d_req || last_d) begin
            d_req   = ($urandom_range(0, 99) < 60);
            d_we    = $urandom_range(0, 1);
            d_addr  = (AW + 2)'($urandom_range(0, 1023));
            d_be    = be_set[$urandom_range(0, 6)];
            d_wdata = $urandom;
         end
         reset = ($urandom_range(0, 199) == 0);
         if (reset) begin last_i = 0; last_d = 0; end
         cycle();
      end
      reset = 0; i_req = 0; d_req = 0;
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
